// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, PC-operation encoding, branch conditions, fetch states.
package cpu_pkg;

  typedef enum logic [1:0] {
    COP_SEQ = 2'b00,
    COP_JMP = 2'b01,
    COP_RET = 2'b10,
    COP_BR  = 2'b11
  } coper_e;

  typedef enum logic [1:0] {
    FS_REQ,
    FS_WAIT,
    FS_VALID
  } fetch_st_e;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_BR   = 4'hF;

  localparam logic [1:0] BC_ALWAYS = 2'b00;
  localparam logic [1:0] BC_ZERO   = 2'b01;
  localparam logic [1:0] BC_CARRY  = 2'b10;
  localparam logic [1:0] BC_NZERO  = 2'b11;

  function automatic logic br_taken(input logic [1:0] cond, input logic z, input logic c);
    case (cond)
      BC_ALWAYS: br_taken = 1'b1;
      BC_ZERO:   br_taken = z;
      BC_CARRY:  br_taken = c;
      default:   br_taken = !z;
    endcase
  endfunction

endpackage

// File: rtl/call_stack.sv
// LIFO of return addresses; pushes when full and pops when empty are ignored here.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] top_sel;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign top_sel = empty_o ? '0 : AW'(cnt_q - CW'(1));
  assign top_o   = mem_q[top_sel];

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[cnt_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: memory handshake FSM, PC register, control-flow decode, interrupt entry.
// Define CALL_STACK_EN to add a hardware call stack for CALL/RET/interrupt return addresses.
module instr_fetch_unit #(
  parameter logic [11:0] INT_VECTOR = 12'h004,
  parameter int          STK_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [11:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        zero_i,
  input  logic        carry_i,
  input  logic        int_i,
  output logic [11:0] pc_o,
  output logic [1:0]  coper_o,
  output logic [7:0]  branch_off_o,
  output logic [11:0] jump_addr_o,
  input  logic [11:0] pc_next_i,
  output logic        stk_err_o
);
  import cpu_pkg::*;

  fetch_st_e   st_q, st_d;
  logic        run_q;
  logic [11:0] pc_q, pc_d;
  logic [15:0] instr_q;
  logic        pend_q, pend_d;
  logic [3:0]  opc;
  logic        accept, capture, service;
  coper_e      coper;
  logic [11:0] jaddr;

  assign opc           = instr_q[15:12];
  // run_q keeps the request low during reset and until the first edge after release
  assign mem_req_o     = run_q && (st_q != FS_VALID);
  assign capture       = mem_req_o && mem_ack_i;
  assign instr_valid_o = (st_q == FS_VALID);
  assign accept        = instr_valid_o && instr_ready_i;
  assign service       = accept && pend_q && (opc < OP_JMP);
  assign pend_d        = int_i || (pend_q && !service);
  assign pc_d          = service ? INT_VECTOR : pc_next_i;

  assign mem_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign branch_off_o  = instr_q[7:0];
  assign coper_o       = coper;
  assign jump_addr_o   = jaddr;

  always_comb begin
    st_d = st_q;
    case (st_q)
      FS_REQ:   if (run_q) st_d = mem_ack_i ? FS_VALID : FS_WAIT;
      FS_WAIT:  if (mem_ack_i) st_d = FS_VALID;
      FS_VALID: if (accept) st_d = FS_REQ;
      default:  st_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= FS_REQ;
      run_q   <= 1'b0;
      pc_q    <= 12'h000;
      instr_q <= 16'h0000;
      pend_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      run_q  <= 1'b1;
      pend_q <= pend_d;
      if (capture) instr_q <= mem_rdata_i;
      if (accept)  pc_q    <= pc_d;
    end
  end

`ifdef CALL_STACK_EN
  logic        stk_push, stk_pop, stk_full, stk_empty, err_q;
  logic [11:0] stk_top, stk_din;

  // An interrupt saves the address the interrupted flow would have continued at
  assign stk_push  = accept && ((opc == OP_CALL) || service);
  assign stk_pop   = accept && (opc == OP_RET) && !stk_empty;
  assign stk_din   = service ? pc_next_i : pc_q + 12'd1;
  assign stk_err_o = err_q;

  call_stack #(.DEPTH(STK_DEPTH), .W(12)) u_call_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (stk_din),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if ((stk_push && stk_full) || (accept && (opc == OP_RET) && stk_empty)) err_q <= 1'b1;
  end
`else
  assign stk_err_o = 1'b0;
`endif

  always_comb begin
    coper = COP_SEQ;
    jaddr = instr_q[11:0];
    case (opc)
      OP_JMP:  coper = COP_JMP;
      OP_CALL: coper = COP_JMP;
      OP_RET: begin
`ifdef CALL_STACK_EN
        if (stk_empty) begin
          jaddr = 12'h000;
        end else begin
          coper = COP_JMP;
          jaddr = stk_top;
        end
`else
        coper = COP_RET;
        jaddr = 12'h000;
`endif
      end
      OP_BR:   if (br_taken(instr_q[9:8], zero_i, carry_i)) coper = COP_BR;
      default: coper = COP_SEQ;
    endcase
    if (!instr_valid_o) coper = COP_SEQ;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized transactions vs a reference model.
module tb_instr_fetch_unit;
  localparam logic [11:0] INT_VEC = 12'h004;
  localparam int          DEPTH   = 8;
`ifdef CALL_STACK_EN
  localparam logic        STK_OVF_EXP = 1'b1;
`else
  localparam logic        STK_OVF_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [11:0] mem_addr_o;
  logic        mem_ack_i;
  logic [15:0] mem_rdata_i;
  logic [15:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        zero_i, carry_i, int_i;
  logic [11:0] pc_o;
  logic [1:0]  coper_o;
  logic [7:0]  branch_off_o;
  logic [11:0] jump_addr_o;
  logic [11:0] pc_next_i;
  logic        stk_err_o;

  always #5 clk = ~clk;

  instr_fetch_unit #(.INT_VECTOR(INT_VEC), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .zero_i(zero_i), .carry_i(carry_i), .int_i(int_i),
    .pc_o(pc_o), .coper_o(coper_o), .branch_off_o(branch_off_o), .jump_addr_o(jump_addr_o),
    .pc_next_i(pc_next_i), .stk_err_o(stk_err_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] m_pc;
  logic        m_pend;
  logic        m_err;
  logic [11:0] m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_pend = 1'b0; m_err = 1'b0;
    m_stk.delete();
  endtask

  // Expected decode of a held instruction given flags and current stack contents
  function automatic void exp_dec(input logic [15:0] ins, input logic z, input logic c,
                                  output logic [1:0] cop, output logic [11:0] ja, output bit jav);
    logic [3:0] op;
    bit cond;
    op = ins[15:12];
    cop = 2'b00; ja = ins[11:0]; jav = 1'b0;
    if (op == 4'hC || op == 4'hD) begin
      cop = 2'b01; jav = 1'b1;
    end else if (op == 4'hE) begin
`ifdef CALL_STACK_EN
      if (m_stk.size() > 0) begin cop = 2'b01; ja = m_stk[$]; jav = 1'b1; end
`else
      cop = 2'b10; ja = 12'h000; jav = 1'b1;
`endif
    end else if (op == 4'hF) begin
      case (ins[9:8])
        2'd0:    cond = 1'b1;
        2'd1:    cond = z;
        2'd2:    cond = c;
        default: cond = !z;
      endcase
      cop = cond ? 2'b11 : 2'b00;
    end
  endfunction

  task automatic model_accept(input logic [15:0] ins, input logic [11:0] pcn, input logic irq);
    logic [3:0] op;
    bit svc;
    op  = ins[15:12];
    svc = m_pend && (op < 4'hC);
`ifdef CALL_STACK_EN
    if (op == 4'hD || svc) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(svc ? pcn : m_pc + 12'd1);
      else m_err = 1'b1;
    end
    if (op == 4'hE) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_err = 1'b1;
    end
`endif
    m_pc   = svc ? INT_VEC : pcn;
    m_pend = irq || (m_pend && !svc);
  endtask

  // One fetch: entered and left just after a falling edge with the DUT requesting
  task automatic txn(input logic [15:0] ins, input int ack_lat, input int rdy_lat,
                     input logic z, input logic cy, input logic irq_wait, input logic irq_acc,
                     input logic [11:0] pcn);
    logic [1:0]  cop;
    logic [11:0] ja;
    bit          jav;
    zero_i = z; carry_i = cy; instr_ready_i = 1'b0; mem_ack_i = 1'b0;
    for (int i = 0; i < ack_lat; i++) begin
      chk("req_wait", mem_req_o, 1); chk("addr_hold", mem_addr_o, m_pc);
      chk("valid_lo", instr_valid_o, 0);
      int_i = irq_wait && (i == 0);
      if (int_i) m_pend = 1'b1;
      adv();
    end
    chk("req", mem_req_o, 1); chk("addr", mem_addr_o, m_pc);
    mem_ack_i = 1'b1; mem_rdata_i = ins;
    int_i = irq_wait && (ack_lat == 0);
    if (int_i) m_pend = 1'b1;
    adv();
    int_i = 1'b0;
    exp_dec(ins, z, cy, cop, ja, jav);
    for (int i = 0; i <= rdy_lat; i++) begin
      mem_ack_i = 1'($urandom); mem_rdata_i = 16'($urandom);
      chk("valid", instr_valid_o, 1); chk("instr", instr_o, ins);
      chk("pc_hold", pc_o, m_pc); chk("req_lo", mem_req_o, 0);
      chk("coper", coper_o, cop); chk("branch_off", branch_off_o, ins[7:0]);
      if (jav) chk("jump_addr", jump_addr_o, ja);
      if (i == rdy_lat) begin
        instr_ready_i = 1'b1; pc_next_i = pcn; int_i = irq_acc;
        model_accept(ins, pcn, irq_acc);
      end
      adv();
    end
    instr_ready_i = 1'b0; int_i = 1'b0; mem_ack_i = 1'b0; pc_next_i = 12'($urandom);
    chk("req_next", mem_req_o, 1); chk("addr_next", mem_addr_o, m_pc);
    chk("valid_next", instr_valid_o, 0); chk("coper_idle", coper_o, 0);
    chk("stk_err", stk_err_o, m_err);
  endtask

  initial begin
    logic [15:0] ins;
    int          sel;
    rst_n = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 16'h0; instr_ready_i = 1'b0;
    zero_i = 1'b0; carry_i = 1'b0; int_i = 1'b0; pc_next_i = 12'h0;
    model_reset();
    adv(); adv();
    chk("rst_req", mem_req_o, 0);     chk("rst_addr", mem_addr_o, 0);
    chk("rst_instr", instr_o, 0);     chk("rst_valid", instr_valid_o, 0);
    chk("rst_pc", pc_o, 0);           chk("rst_coper", coper_o, 0);
    chk("rst_boff", branch_off_o, 0); chk("rst_jaddr", jump_addr_o, 0);
    chk("rst_stkerr", stk_err_o, 0);
    rst_n = 1'b1;
    chk("req_before_edge", mem_req_o, 0);
    adv();

    txn(16'h1234, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001);
    chk("seq_next_addr", mem_addr_o, 12'h001);
    txn(16'hF105, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020);
    txn(16'hF105, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h021);
    txn(16'h2345, 0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 12'h022);
    txn(16'hC0AB, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0AB);
    txn(16'h3000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AC);
    chk("int_vector", mem_addr_o, INT_VEC);
    txn(16'h3001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h050);
    chk("pend_cleared", mem_addr_o, 12'h050);
    txn(16'h4000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h060);
    chk("int_keep_svc", mem_addr_o, INT_VEC);
    txn(16'h4001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h070);
    chk("int_kept_pending", mem_addr_o, INT_VEC);
    txn(16'h5000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C5);

    // Reset asserted while waiting for memory
    chk("req_pre_wait", mem_req_o, 1);
    adv();
    chk("wait_req", mem_req_o, 1); chk("wait_addr", mem_addr_o, 12'h3C5);
    rst_n = 1'b0; #1;
    chk("rst_wait_req", mem_req_o, 0); chk("rst_wait_addr", mem_addr_o, 0);
    chk("rst_wait_valid", instr_valid_o, 0);
    adv();
    rst_n = 1'b1; model_reset();
    adv();
    chk("restart_addr", mem_addr_o, 12'h000);

    txn(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010);
    txn(16'hD200, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h200);
    txn(16'hE000, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h011);
    for (int i = 0; i < 9; i++)
      txn(16'hD300 | 16'(i), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h300 + 12'(i));
    chk("stk_overflow", stk_err_o, STK_OVF_EXP);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        4:       ins = {4'hC, 12'($urandom)};
        5:       ins = {4'hD, 12'($urandom)};
        6:       ins = {4'hE, 12'($urandom)};
        7:       ins = {4'hF, 12'($urandom)};
        default: ins = {4'($urandom_range(0, 11)), 12'($urandom)};
      endcase
      txn(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
